ps2_key_tracker: RTL and testbench

- Converts the byte stream from the PS/2 receiver into the 8-bit held-key bitmap consumed by user_control's kb_in.
- Decodes make, break, extended (E0) and pause (E1) sequences and keeps one "held" bit per mapped key.
- Sits between the PS/2 byte receiver and user_control on the 50 MHz (20 ns) system clock.

---
 rtl/ps2_key_tracker.sv | 178 +++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode decoder producing the 8-bit held-key bitmap for user_control.
// Define KB_AUTO_RELEASE_EN to add per-key auto-release after RELEASE_CYCLES without a make.
module ps2_key_tracker #(
  parameter int PREFIX_TIMEOUT = 250_000,
  parameter int RELEASE_CYCLES = 30_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] code_in,
  input  logic       code_valid_in,
  output logic [7:0] kb_out,
  output logic       change_out,
  output logic       err_out
);

  localparam int TW = $clog2(PREFIX_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, PAUSE} state_e;

  state_e        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    kb_q, kb_d, kb_dec;
  logic          chg_q, chg_d;
  logic          err_q, err_d;
  logic          byte_ovf, byte_ign;

  function automatic logic [7:0] map_std(input logic [7:0] code);
    case (code)
      8'h1D:   map_std = 8'h80;
      8'h1B:   map_std = 8'h40;
      8'h1C:   map_std = 8'h20;
      8'h23:   map_std = 8'h10;
      default: map_std = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] map_ext(input logic [7:0] code);
    case (code)
      8'h75:   map_ext = 8'h08;
      8'h72:   map_ext = 8'h04;
      8'h6B:   map_ext = 8'h02;
      8'h74:   map_ext = 8'h01;
      default: map_ext = 8'h00;
    endcase
  endfunction

  assign byte_ovf = (code_in == 8'h00) || (code_in == 8'hFF);
  assign byte_ign = (code_in == 8'hAA) || (code_in == 8'hFA) || (code_in == 8'hFE);

  // A valid byte always beats a prefix timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    kb_dec  = kb_q;
    err_d   = 1'b0;
    if (code_valid_in) begin
      tmo_d = '0;
      if (byte_ovf) begin
        kb_dec  = '0;
        err_d   = 1'b1;
        state_d = IDLE;
        skip_d  = '0;
      end else if (!byte_ign) begin
        case (state_q)
          IDLE: begin
            if (code_in == 8'hF0) begin
              state_d = BRK;
            end else if (code_in == 8'hE0) begin
              state_d = EXT;
            end else if (code_in == 8'hE1) begin
              state_d = PAUSE;
              skip_d  = 3'd7;
            end else begin
              kb_dec = kb_q | map_std(code_in);
            end
          end
          BRK: begin
            kb_dec  = kb_q & ~map_std(code_in);
            state_d = IDLE;
          end
          EXT: begin
            if (code_in == 8'hF0) begin
              state_d = EXT_BRK;
            end else begin
              kb_dec  = kb_q | map_ext(code_in);
              state_d = IDLE;
            end
          end
          EXT_BRK: begin
            kb_dec  = kb_q & ~map_ext(code_in);
            state_d = IDLE;
          end
          PAUSE: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
        skip_d  = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

`ifdef KB_AUTO_RELEASE_EN
  localparam int RW = $clog2(RELEASE_CYCLES);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

  logic [7:0]    make_mask, expire;
  logic [RW-1:0] rel_q [8];
  logic [RW-1:0] rel_d [8];

  // Keys made (or repeated) this cycle; these reload their idle counter.
  always_comb begin
    make_mask = '0;
    if (code_valid_in && !byte_ovf && !byte_ign) begin
      if (state_q == IDLE && code_in != 8'hF0 && code_in != 8'hE0 && code_in != 8'hE1)
        make_mask = map_std(code_in);
      else if (state_q == EXT && code_in != 8'hF0)
        make_mask = map_ext(code_in);
    end
  end

  always_comb begin
    expire = '0;
    for (int i = 0; i < 8; i++)
      expire[i] = kb_q[i] & ~make_mask[i] & (rel_q[i] == REL_LAST);
    kb_d = kb_dec & ~expire;
    for (int i = 0; i < 8; i++)
      rel_d[i] = (make_mask[i] || !kb_d[i]) ? '0 : rel_q[i] + RW'(1);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 8; i++) rel_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) rel_q[i] <= rel_d[i];
    end
  end
`else
  assign kb_d = kb_dec;
`endif

  assign chg_d = (kb_d != kb_q);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
      kb_q    <= '0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      kb_q    <= kb_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

  assign kb_out     = kb_q;
  assign change_out = chg_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed and randomized bench for ps2_key_tracker against a prefix-queue reference model.
module tb_ps2_key_tracker;
  localparam int PT = 16;
  localparam int RC = 32;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       code_valid_in = 1'b0;
  logic [7:0] kb_out;
  logic       change_out;
  logic       err_out;

  ps2_key_tracker #(.PREFIX_TIMEOUT(PT), .RELEASE_CYCLES(RC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .code_in(code_in), .code_valid_in(code_valid_in),
    .kb_out(kb_out), .change_out(change_out), .err_out(err_out)
  );

  always #10 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int chg_seen = 0;

  // Reference model: pending prefix bytes, remaining pause bytes, quiet cycles, key ages.
  logic [7:0] m_kb;
  logic       m_chg, m_err;
  logic [7:0] pend[$];
  int         pause_left, quiet;
  int         age[8];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic int key_idx(input logic [7:0] c, input bit ext);
    if (!ext) begin
      case (c)
        8'h1D: return 7;  8'h1B: return 6;  8'h1C: return 5;  8'h23: return 4;
        default: return -1;
      endcase
    end
    case (c)
      8'h75: return 3;  8'h72: return 2;  8'h6B: return 1;  8'h74: return 0;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_kb = '0; m_chg = 1'b0; m_err = 1'b0;
    pend.delete(); pause_left = 0; quiet = 0;
    for (int i = 0; i < 8; i++) age[i] = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] c);
    logic [7:0] old;
    logic [7:0] made;
    bit ext, brk;
    int k;
    old = m_kb; made = '0; m_err = 1'b0;
    if (v) begin
      quiet = 0;
      if (c == 8'h00 || c == 8'hFF) begin
        m_kb = '0; pend.delete(); pause_left = 0; m_err = 1'b1;
      end else if (c == 8'hAA || c == 8'hFA || c == 8'hFE) begin
      end else if (pause_left > 0) begin
        pause_left--;
      end else if (pend.size() == 0 && c == 8'hE1) begin
        pause_left = 7;
      end else if (pend.size() == 0 && c == 8'hE0) begin
        pend.push_back(c);
      end else if (c == 8'hF0 && (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0))) begin
        pend.push_back(c);
      end else begin
        ext = (pend.size() > 0) && (pend[0] == 8'hE0);
        brk = (pend.size() > 0) && (pend[pend.size()-1] == 8'hF0);
        k = key_idx(c, ext);
        if (k >= 0) begin
          if (brk) m_kb[k] = 1'b0;
          else begin m_kb[k] = 1'b1; made[k] = 1'b1; age[k] = 0; end
        end
        pend.delete();
      end
    end else if (pend.size() > 0 || pause_left > 0) begin
      quiet++;
      if (quiet >= PT) begin
        pend.delete(); pause_left = 0; quiet = 0; m_err = 1'b1;
      end
    end
`ifdef KB_AUTO_RELEASE_EN
    for (int i = 0; i < 8; i++) begin
      if (old[i] && m_kb[i] && !made[i]) begin
        age[i]++;
        if (age[i] >= RC) m_kb[i] = 1'b0;
      end
    end
`endif
    m_chg = (m_kb != old);
  endtask

  // One clock: drive, clock, sample 1 ns after the edge, compare with the model.
  task automatic cyc(input bit v, input logic [7:0] c);
    code_valid_in = v;
    code_in = v ? c : 8'($urandom);
    @(posedge clk_in);
    #1;
    model_step(v, c);
    chk("kb_out", kb_out, m_kb);
    chk("change_out", {7'd0, change_out}, {7'd0, m_chg});
    chk("err_out", {7'd0, err_out}, {7'd0, m_err});
    if (err_out) err_seen++;
    if (change_out) chg_seen++;
    code_valid_in = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    cyc(1'b1, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  int base_err;
  int r, gap;
  logic [7:0] pool [19] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hE0,
                            8'hF0, 8'hF0, 8'hE1, 8'h14, 8'h77, 8'hAA, 8'hFA, 8'hFE, 8'h5A};

  initial begin
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_kb", kb_out, 8'h00);
    chk("reset_chg", {7'd0, change_out}, 8'h00);
    chk("reset_err", {7'd0, err_out}, 8'h00);
    rst_in = 1'b1;
    idle(2);

    // W make / repeat / break
    send(8'h1D);
    chk("w_make", kb_out, 8'h80);
    chk("w_make_pulse", {7'd0, change_out}, 8'h01);
    send(8'h1D);
    chk("w_repeat_nopulse", {7'd0, change_out}, 8'h00);
    send(8'hF0); send(8'h1D);
    chk("w_break", kb_out, 8'h00);
    chk("w_break_pulse", {7'd0, change_out}, 8'h01);

    // Extended keys
    chg_seen = 0;
    send(8'hE0); send(8'h75);
    chk("ext_up", kb_out, 8'h08);
    send(8'hE0); send(8'h6B);
    chk("ext_up_left", kb_out, 8'h0A);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_left_only", kb_out, 8'h02);
    chk("ext_pulse_count", 8'(chg_seen), 8'd3);
    send(8'hE0); send(8'hF0); send(8'h6B);

    // Overflow byte clears everything
    send(8'h1D); send(8'h1C);
    base_err = err_seen;
    send(8'hFF);
    chk("ovf_clear", kb_out, 8'h00);
    chk("ovf_err", {7'd0, err_out}, 8'h01);
    send(8'h1B);
    chk("after_ovf", kb_out, 8'h40);
    chk("ovf_err_count", 8'(err_seen - base_err), 8'd1);
    send(8'hF0); send(8'h00);

    // Prefix timeout
    base_err = err_seen;
    send(8'hE0);
    idle(PT);
    chk("tmo_err", {7'd0, err_out}, 8'h01);
    send(8'h75);
    chk("tmo_then_75", kb_out, 8'h00);
    chk("tmo_err_count", 8'(err_seen - base_err), 8'd1);

    // Byte arriving on the timeout cycle wins
    base_err = err_seen;
    send(8'hE0);
    idle(PT - 1);
    send(8'h75);
    chk("tmo_byte_wins", kb_out, 8'h08);
    chk("tmo_byte_noerr", 8'(err_seen - base_err), 8'd0);
    send(8'hE0); send(8'hF0); send(8'h75);

    // Ignored bytes keep prefix state
    send(8'hE0); send(8'hFA); send(8'h72);
    chk("ack_in_prefix", kb_out, 8'h04);
    send(8'hE0); send(8'hF0); send(8'hAA); send(8'h72);
    chk("bat_in_brk", kb_out, 8'h00);

    // Pause sequence
    base_err = err_seen;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_quiet", kb_out, 8'h00);
    send(8'h23);
    chk("after_pause", kb_out, 8'h10);
    chk("pause_noerr", 8'(err_seen - base_err), 8'd0);
    send(8'hF0); send(8'h23);

`ifdef KB_AUTO_RELEASE_EN
    send(8'h1C);
    idle(RC - 1);
    chk("ar_still_held", kb_out, 8'h20);
    idle(1);
    chk("ar_released", kb_out, 8'h00);
    chk("ar_pulse", {7'd0, change_out}, 8'h01);
    send(8'h1C);
    for (int i = 0; i < 5; i++) begin
      idle(19);
      send(8'h1C);
    end
    chk("ar_refresh", kb_out, 8'h20);
    send(8'hF0); send(8'h1C);
`endif

    // Asynchronous reset mid-sequence
    send(8'h1D); send(8'hE0);
    #4 rst_in = 1'b0;
    #1;
    chk("async_rst_kb", kb_out, 8'h00);
    chk("async_rst_chg", {7'd0, change_out}, 8'h00);
    chk("async_rst_err", {7'd0, err_out}, 8'h00);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    idle(PT + 2);
    chk("post_rst_quiet", kb_out, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) gap = 0;
      else if (r < 95) gap = $urandom_range(1, 5);
      else gap = $urandom_range(PT - 2, PT + 4);
      idle(gap);
      if ($urandom_range(0, 99) < 2) send(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
      else send(pool[$urandom_range(0, 18)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
